seq_pattern_tx: RTL
===================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8, giving the maximum pattern width in bits (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin a transmission.
REQ-005 The block SHALL have port stop, input, 1 bit, the request to end after the current repetition.
REQ-006 The block SHALL have port pattern, input, PAT_W bits, the bit pattern, sent MSB-first from bit pat_len-1.
REQ-007 The block SHALL have port pat_len, input, 4 bits, the number of pattern bits to send.
REQ-008 The block SHALL have port reps, input, 4 bits, the repetition count, where 0 means continuous.
REQ-009 The block SHALL have port gap, input, 4 bits, the number of idle bits between repetitions.
REQ-010 The block SHALL have port x_out, output, 1 bit, the serial data bit.
REQ-011 The block SHALL have port valid, output, 1 bit, which is high while x_out carries a pattern bit.
REQ-012 The block SHALL have port busy, output, 1 bit, which is high while a transmission is in progress.
REQ-013 The block SHALL have port frame, output, 1 bit, which is high on the last bit of each repetition.
REQ-014 The block SHALL have port done, output, 1 bit, which is high on the last bit of the final repetition.

Function
REQ-015 The block SHALL use the states IDLE, SEND and GAP, and all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with pat_len!=0 SHALL latch pattern, pat_len (clamped to PAT_W), reps and gap, and SHALL enter SEND.
REQ-017 The first bit SHALL appear on x_out with valid=1 and busy=1 in the cycle after start is sampled, which is 1-cycle latency.
REQ-018 start=1 with pat_len=0 SHALL be ignored, and the block SHALL remain in IDLE with busy=0.
REQ-019 start while busy=1 SHALL be ignored, and input changes while busy SHALL have no effect.
REQ-020 SEND SHALL emit one bit per cycle, down-counting a bit index from pat_len-1 to 0.
REQ-021 frame SHALL be 1 on bit index 0 of every repetition and 0 otherwise.
REQ-022 After a repetition, if the repetitions are exhausted (reps!=0) or stop was seen, the block SHALL return to IDLE, with done=1 on that last bit.
REQ-023 After a repetition that is not the last, the block SHALL go to GAP when the latched gap is nonzero and SEQ_TX_GAP_EN is defined, and SHALL otherwise restart SEND at the next cycle with no idle bit.
REQ-024 GAP SHALL hold x_out=0, valid=0 and busy=1 for exactly gap cycles, then return to SEND.
REQ-025 stop=1 sampled in any SEND or GAP cycle SHALL be remembered until the current repetition's last bit completes; no partial pattern SHALL ever be emitted.
REQ-026 When stop is seen during GAP, the block SHALL go to IDLE at the end of the gap without sending again, with done=1 in the final GAP cycle.
REQ-027 stop in IDLE SHALL be ignored.
REQ-028 With reps=0, the block SHALL repeat until stop.
REQ-029 The repetition counter SHALL be 4 bits wide and SHALL NOT wrap.
REQ-030 busy SHALL fall in the cycle after done=1.
REQ-031 A new start SHALL be accepted in the first cycle with busy=0.
REQ-032 In IDLE, x_out, valid, frame and done SHALL all be 0.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE and set x_out, valid, busy, frame and done to 0, and SHALL clear all counters and the pending stop.
REQ-034 Reset mid-transmission SHALL abandon the transmission, with no done pulse.
REQ-035 The first start SHALL be honoured on the first rising clock edge after rst deasserts.

Configuration
REQ-036 When macro SEQ_TX_GAP_EN is defined, the GAP state and gap handling SHALL be compiled in.
REQ-037 When SEQ_TX_GAP_EN is undefined, the gap port SHALL remain present but be ignored, GAP SHALL be absent, and repetitions SHALL be back-to-back.

Verification
REQ-038 The bench SHALL cover: pattern=5'b11101, pat_len=5, reps=1 -> x_out=1,1,1,0,1 with valid=1 in cycles 1-5; frame=1 and done=1 in cycle 5; busy=0 in cycle 6.
REQ-039 The bench SHALL cover: pattern=11101, reps=2, gap=0 -> 10 consecutive valid bits 1110111101, frame in cycles 5 and 10, done in cycle 10 only.
REQ-040 The bench SHALL cover: with SEQ_TX_GAP_EN, reps=2, gap=3 -> bits in cycles 1-5, valid=0 and x_out=0 in cycles 6-8, bits in cycles 9-13, done in cycle 13.
REQ-041 The bench SHALL cover: reps=0, stop pulsed in cycle 7 -> the second repetition completes at cycle 10 with done=1, then IDLE.
REQ-042 The bench SHALL cover: start with pat_len=0 -> busy stays 0; start at cycle 3 while busy -> ignored, output unchanged.
REQ-043 The bench SHALL cover: rst asserted in cycle 3 of a transmission -> all outputs 0 immediately, no done pulse, and a fresh start sends the full pattern.

Source files
------------

// File: rtl/seq_pattern_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter. It latches a bit pattern of up to
//               PAT_W bits and shifts it out MSB-first, once or repeatedly,
//               with optional idle gaps between repetitions. All outputs are
//               registered.
// Options     : Defining SEQ_TX_GAP_EN compiles in the GAP state. Without it,
//               the gap port is ignored and repetitions are back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       pat_len,
  input  logic [3:0]       reps,
  input  logic [3:0]       gap,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             frame,
  output logic             done
);

  localparam logic [3:0]       c_pat_w = 4'(PAT_W);
  localparam logic [PAT_W-1:0] c_one   = PAT_W'(1);

`ifdef SEQ_TX_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
  // The gap port stays on the interface but has no function in this build.
  logic unused_gap;
  assign unused_gap = ^gap;
`endif

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         reps_q, reps_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         rep_cnt_q, rep_cnt_d;
  logic               stop_q, stop_d;
`ifdef SEQ_TX_GAP_EN
  logic [3:0]         gap_q, gap_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
`endif
  logic               x_out_q, x_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;

  // Helper terms shared by the next-state logic.
  logic [3:0]         len_clamp;
  logic               stop_seen;
  logic [3:0]         rep_inc;
  logic               last_rep;
  logic               last_rep_next;

  // Next-state and next-output logic. The outputs are computed for the cycle
  // being entered, so the decision to flag done is made one bit ahead and the
  // registered done_q then tells the FSM whether to stop after this bit.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    reps_d    = reps_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    stop_d    = stop_q;
`ifdef SEQ_TX_GAP_EN
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
`endif
    x_out_d   = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    frame_d   = 1'b0;
    done_d    = 1'b0;

    len_clamp     = (pat_len > c_pat_w) ? c_pat_w : pat_len;
    stop_seen     = stop_q | stop;
    // Saturating repetition count: never wraps back into a matching value.
    rep_inc       = (rep_cnt_q == 4'hF) ? 4'hF : rep_cnt_q + 4'd1;
    last_rep      = (reps_q != 4'd0) && (rep_cnt_q == reps_q);
    last_rep_next = (reps_q != 4'd0) && (rep_inc == reps_q);

    case (state_q)
      IDLE: begin
        // stop is deliberately not sampled here.
        if (start && (pat_len != 4'd0)) begin
          state_d   = SEND;
          pat_d     = pattern;
          len_d     = len_clamp;
          reps_d    = reps;
`ifdef SEQ_TX_GAP_EN
          gap_d     = gap;
`endif
          rep_cnt_d = 4'd1;
          stop_d    = 1'b0;
          bit_idx_d = len_clamp - 4'd1;
          done_d    = (len_clamp == 4'd1) && (reps == 4'd1);
        end
      end

      SEND: begin
        stop_d = stop_seen;
        if (bit_idx_q != 4'd0) begin
          bit_idx_d = bit_idx_q - 4'd1;
          done_d    = (bit_idx_q == 4'd1) && (last_rep || stop_seen);
        end else if (done_q) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end
`ifdef SEQ_TX_GAP_EN
        else if (gap_q != 4'd0) begin
          state_d   = GAP;
          gap_cnt_d = gap_q;
          done_d    = (gap_q == 4'd1) && stop_seen;
        end
`endif
        else begin
          rep_cnt_d = rep_inc;
          bit_idx_d = len_q - 4'd1;
          done_d    = (len_q == 4'd1) && (last_rep_next || stop_seen);
        end
      end

`ifdef SEQ_TX_GAP_EN
      GAP: begin
        stop_d = stop_seen;
        if (gap_cnt_q == 4'd1) begin
          if (done_q) begin
            state_d = IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d   = SEND;
            rep_cnt_d = rep_inc;
            bit_idx_d = len_q - 4'd1;
            done_d    = (len_q == 4'd1) && (last_rep_next || stop_seen);
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          done_d    = (gap_cnt_q == 4'd2) && stop_seen;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // Data-path outputs follow directly from the state being entered.
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == SEND);
    x_out_d = valid_d && |(pat_d & (c_one << bit_idx_d));
    frame_d = valid_d && (bit_idx_d == 4'd0);
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      bit_idx_q <= '0;
      rep_cnt_q <= '0;
      stop_q    <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
      x_out_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
      stop_q    <= stop_d;
`ifdef SEQ_TX_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
      x_out_q   <= x_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  assign x_out = x_out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule
`default_nettype wire
